// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared types for the pipeline hazard/sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    localparam logic [4:0] C_REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb_en;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
    } stage_tag_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : ID-side inputs and pipeline control outputs of pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    import riscv_pipe_pkg::*;

    logic             id_valid;
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic [4:0]       id_rd_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_writeback_en;
    logic             id_is_load;
    logic             ex_redirect;
    logic             id_stall;
    logic             id_flush;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic             wb_writeback_en;
    logic [4:0]       wb_rd_addr;
    fwd_sel_t         fwd_rs1_sel;
    fwd_sel_t         fwd_rs2_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1,
               id_uses_rs2, id_writeback_en, id_is_load, ex_redirect,
        input  id_stall, id_flush, ex_valid, mem_valid, wb_valid,
               wb_writeback_en, wb_rd_addr, fwd_rs1_sel, fwd_rs2_sel,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1,
               id_uses_rs2, id_writeback_en, id_is_load, ex_redirect,
        output id_stall, id_flush, ex_valid, mem_valid, wb_valid,
               wb_writeback_en, wb_rd_addr, fwd_rs1_sel, fwd_rs2_sel,
               stall_count, flush_count
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that holds at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count_q;
    logic [W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (inc && !(&r_count_q)) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Load-use stall, redirect flush and EX operand forwarding for
//               a 5-stage pipeline, with saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);

    stage_tag_t r_ex_tag_q,  w_ex_tag_d;
    stage_tag_t r_mem_tag_q, w_mem_tag_d;
    stage_tag_t r_wb_tag_q,  w_wb_tag_d;

    logic     w_load_use;
    logic     w_stall;
    logic     w_flush;
    logic     w_mem_fwd_ok;
    logic     w_wb_fwd_ok;
    fwd_sel_t w_fwd_rs1;
    fwd_sel_t w_fwd_rs2;
    logic     w_unused_wb;

    always_comb begin
        w_load_use = bus.id_valid & r_ex_tag_q.valid & r_ex_tag_q.is_load & r_ex_tag_q.wb_en &
                     ((bus.id_uses_rs1 & (bus.id_rs1_addr == r_ex_tag_q.rd)) |
                      (bus.id_uses_rs2 & (bus.id_rs2_addr == r_ex_tag_q.rd)));
        // Redirect wins: the dependent instruction in ID is being discarded anyway.
        w_stall    = w_load_use & ~bus.ex_redirect & ~rst;
        w_flush    = bus.ex_redirect & ~rst;
    end

    always_comb begin
        w_ex_tag_d = '0;
        if (bus.id_valid && !w_load_use && !bus.ex_redirect) begin
            w_ex_tag_d.valid    = 1'b1;
            w_ex_tag_d.rd       = bus.id_rd_addr;
            w_ex_tag_d.wb_en    = bus.id_writeback_en & (bus.id_rd_addr != C_REG_X0);
            w_ex_tag_d.is_load  = bus.id_is_load;
            w_ex_tag_d.rs1      = bus.id_rs1_addr;
            w_ex_tag_d.rs2      = bus.id_rs2_addr;
            w_ex_tag_d.uses_rs1 = bus.id_uses_rs1;
            w_ex_tag_d.uses_rs2 = bus.id_uses_rs2;
        end
        w_mem_tag_d = r_ex_tag_q;
        w_wb_tag_d  = r_mem_tag_q;
    end

    // A load in MEM has no data yet; the load-use stall covers that case.
    always_comb begin
        w_mem_fwd_ok = r_mem_tag_q.valid & r_mem_tag_q.wb_en & ~r_mem_tag_q.is_load;
        w_wb_fwd_ok  = r_wb_tag_q.valid & r_wb_tag_q.wb_en;
        w_fwd_rs1    = FWD_RF;
        w_fwd_rs2    = FWD_RF;
        if (!rst && r_ex_tag_q.uses_rs1) begin
            if (w_mem_fwd_ok && (r_mem_tag_q.rd == r_ex_tag_q.rs1)) begin
                w_fwd_rs1 = FWD_MEM;
            end else if (w_wb_fwd_ok && (r_wb_tag_q.rd == r_ex_tag_q.rs1)) begin
                w_fwd_rs1 = FWD_WB;
            end
        end
        if (!rst && r_ex_tag_q.uses_rs2) begin
            if (w_mem_fwd_ok && (r_mem_tag_q.rd == r_ex_tag_q.rs2)) begin
                w_fwd_rs2 = FWD_MEM;
            end else if (w_wb_fwd_ok && (r_wb_tag_q.rd == r_ex_tag_q.rs2)) begin
                w_fwd_rs2 = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_tag_q  <= '0;
            r_mem_tag_q <= '0;
            r_wb_tag_q  <= '0;
        end else begin
            r_ex_tag_q  <= w_ex_tag_d;
            r_mem_tag_q <= w_mem_tag_d;
            r_wb_tag_q  <= w_wb_tag_d;
        end
    end

    assign w_unused_wb = ^{r_wb_tag_q.is_load, r_wb_tag_q.rs1, r_wb_tag_q.rs2,
                           r_wb_tag_q.uses_rs1, r_wb_tag_q.uses_rs2};

    assign bus.id_stall        = w_stall;
    assign bus.id_flush        = w_flush;
    assign bus.ex_valid        = r_ex_tag_q.valid;
    assign bus.mem_valid       = r_mem_tag_q.valid;
    assign bus.wb_valid        = r_wb_tag_q.valid;
    assign bus.wb_writeback_en = w_wb_fwd_ok & ~rst;
    assign bus.wb_rd_addr      = rst ? C_REG_X0 : r_wb_tag_q.rd;
    assign bus.fwd_rs1_sel     = w_fwd_rs1;
    assign bus.fwd_rs2_sel     = w_fwd_rs2;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (bus.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush),
        .count (bus.flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl (CNT_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;
    import riscv_pipe_pkg::*;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic wb, input logic ld);
        bus.id_valid        = v;
        bus.id_rs1_addr     = rs1;
        bus.id_rs2_addr     = rs2;
        bus.id_rd_addr      = rd;
        bus.id_uses_rs1     = u1;
        bus.id_uses_rs2     = u2;
        bus.id_writeback_en = wb;
        bus.id_is_load      = ld;
    endtask

    task automatic idle(input int n);
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.ex_redirect = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_id(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        bus.ex_redirect = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b expected 0", bus.id_stall); end
        checks++; if (bus.id_flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %0b expected 0", bus.id_flush); end
        checks++; if (bus.wb_writeback_en !== 1'b0) begin errors++; $display("FAIL rst_wbwe: got %0b expected 0", bus.wb_writeback_en); end
        checks++; if (bus.wb_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_wbrd: got %0d expected 0", bus.wb_rd_addr); end
        checks++; if (bus.fwd_rs1_sel !== FWD_RF || bus.fwd_rs2_sel !== FWD_RF) begin errors++; $display("FAIL rst_fwd: got %0d/%0d expected 0/0", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        checks++; if ({bus.ex_valid, bus.mem_valid, bus.wb_valid} !== 3'b000) begin errors++; $display("FAIL rst_valids: got %b expected 000", {bus.ex_valid, bus.mem_valid, bus.wb_valid}); end
        checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", bus.stall_count, bus.flush_count); end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_back_to_back();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);  // add x3,x1,x2
        #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall0: got %0b expected 0", bus.id_stall); end
        tick();
        drive_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);  // add x4,x3,x3
        #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %0b expected 0", bus.id_stall); end
        tick();
        idle(0);
        #1;
        checks++; if (bus.fwd_rs1_sel !== FWD_MEM) begin errors++; $display("FAIL b2b_fwd1: got %0d expected %0d", bus.fwd_rs1_sel, FWD_MEM); end
        checks++; if (bus.fwd_rs2_sel !== FWD_MEM) begin errors++; $display("FAIL b2b_fwd2: got %0d expected %0d", bus.fwd_rs2_sel, FWD_MEM); end
        tick();
        checks++; if (bus.wb_writeback_en !== 1'b1 || bus.wb_rd_addr !== 5'd3) begin errors++; $display("FAIL b2b_wb: got %0b/%0d expected 1/3", bus.wb_writeback_en, bus.wb_rd_addr); end
        idle(3);
    endtask

    task automatic test_distance2();
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);  // add x5,x1,x2
        tick();
        idle(0);
        #1;
        checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lat_ex: got %0b expected 1", bus.ex_valid); end
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);  // xor x6,x5,x0
        #1;
        checks++; if (bus.mem_valid !== 1'b1 || bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lat_mem: got ex=%0b mem=%0b expected ex=0 mem=1", bus.ex_valid, bus.mem_valid); end
        tick();
        idle(0);
        #1;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL lat_wb: got %0b expected 1", bus.wb_valid); end
        checks++; if (bus.fwd_rs1_sel !== FWD_WB) begin errors++; $display("FAIL d2_fwd1: got %0d expected %0d", bus.fwd_rs1_sel, FWD_WB); end
        checks++; if (bus.fwd_rs2_sel !== FWD_RF) begin errors++; $display("FAIL d2_fwd2: got %0d expected %0d", bus.fwd_rs2_sel, FWD_RF); end
        idle(3);
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);  // lw x7,0(x1)
        tick();
        drive_id(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);  // add x8,x7,x1
        #1;
        checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b expected 1", bus.id_stall); end
        tick();
        #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %0b expected 0", bus.id_stall); end
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0b expected 0", bus.ex_valid); end
        tick();
        idle(0);
        #1;
        checks++; if (bus.fwd_rs1_sel !== FWD_WB || bus.fwd_rs2_sel !== FWD_RF) begin errors++; $display("FAIL lu_fwd: got %0d/%0d expected 2/0", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", bus.stall_count); end
        idle(3);
    endtask

    task automatic test_redirect();
        drive_id(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1); // lw x10,0(x1)
        tick();
        drive_id(1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.ex_redirect = 1'b1;
        #1;
        checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("FAIL rd_stall: got %0b expected 0", bus.id_stall); end
        checks++; if (bus.id_flush !== 1'b1) begin errors++; $display("FAIL rd_flush: got %0b expected 1", bus.id_flush); end
        tick();
        idle(0);
        #1;
        checks++; if (bus.ex_valid !== 1'b0 || bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rd_tags: got ex=%0b mem=%0b expected ex=0 mem=1", bus.ex_valid, bus.mem_valid); end
        checks++; if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'd1) begin errors++; $display("FAIL rd_counts: got flush=%0d stall=%0d expected 1/1", bus.flush_count, bus.stall_count); end
        idle(3);
    endtask

    task automatic test_x0();
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);  // add x0,x1,x2
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);  // add x9,x0,x0
        tick();
        idle(0);
        #1;
        checks++; if (bus.fwd_rs1_sel !== FWD_RF || bus.fwd_rs2_sel !== FWD_RF) begin errors++; $display("FAIL x0_fwd: got %0d/%0d expected 0/0", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        tick();
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_writeback_en !== 1'b0) begin errors++; $display("FAIL x0_wb: got valid=%0b we=%0b expected 1/0", bus.wb_valid, bus.wb_writeback_en); end
        idle(3);
    endtask

    task automatic test_reset_midstream();
        drive_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        idle(0);
        #1;
        checks++; if ({bus.ex_valid, bus.mem_valid, bus.wb_valid} !== 3'b111) begin errors++; $display("FAIL mid_full: got %b expected 111", {bus.ex_valid, bus.mem_valid, bus.wb_valid}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({bus.ex_valid, bus.mem_valid, bus.wb_valid} !== 3'b000) begin errors++; $display("FAIL mid_valids: got %b expected 000", {bus.ex_valid, bus.mem_valid, bus.wb_valid}); end
        checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin errors++; $display("FAIL mid_counts: got %0d/%0d expected 0/0", bus.stall_count, bus.flush_count); end
        checks++; if (bus.wb_writeback_en !== 1'b0) begin errors++; $display("FAIL mid_wbwe: got %0b expected 0", bus.wb_writeback_en); end
    endtask

    task automatic test_saturation();
        // lw x7,0(x7) repeated: stalls on every other cycle.
        drive_id(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        checks++; if (bus.stall_count !== 4'd5) begin errors++; $display("FAIL sat_mid: got %0d expected 5", bus.stall_count); end
        for (int i = 0; i < 40; i++) tick();
        checks++; if (bus.stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", bus.stall_count); end
        idle(3);
    endtask

    initial begin
        bus.ex_redirect = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_redirect();
        test_x0();
        test_reset_midstream();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipelined RISC-V core (IF, ID, EX, MEM, WB). It shadows the EX, MEM and WB stages with valid, destination-register and write-enable tags, and drives the following pipeline controls:
- operand-forwarding selects for the instruction in EX;
- load-use stall of IF/ID;
- bubble insertion into EX;
- flushing of IF/ID on a taken-branch redirect.

It also keeps stall and flush event counters for bring-up.

## Interface
Parameters:
- CNT_W, 32, width of the saturating event counters

Ports:
- clk  input  1  core clock
- rst  input  1  reset; synchronous, active-high
- id_valid  input  1  ID holds a real instruction
- id_rs1_addr  input  5  ID source 1
- id_rs2_addr  input  5  ID source 2
- id_rd_addr  input  5  ID destination
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2 (register-register ALU, store, branch)
- id_writeback_en  input  1  ID instruction writes rd
- id_is_load  input  1  ID instruction is a load
- ex_redirect  input  1  EX resolved a taken branch/jump this cycle
- id_stall  output  1  hold PC and IF/ID register
- id_flush  output  1  invalidate IF/ID register
- ex_valid, mem_valid, wb_valid  output  1 each  stage valid tags
- wb_writeback_en  output  1  register-file write strobe (wb_valid & WB wb_en tag)
- wb_rd_addr  output  5  register-file write address
- fwd_rs1_sel  output  2  EX operand-1 source, type fwd_sel_t
- fwd_rs2_sel  output  2  EX operand-2 source, type fwd_sel_t
- stall_count  output  CNT_W  cycles with id_stall high
- flush_count  output  CNT_W  cycles with id_flush high

## Operation
Stage tags:
- Each of EX, MEM and WB holds a tag: valid, rd, wb_en, is_load.
- The EX tag also holds rs1, rs2, uses_rs1 and uses_rs2.
- Every cycle the tags shift EX→MEM→WB unconditionally; MEM and WB never stall.

ID→EX transfer:
- If id_valid & !id_stall & !ex_redirect, the EX tag loads the ID fields.
- Otherwise EX loads a bubble (valid=0).
- A tag with rd==0 is stored with wb_en=0, so x0 is never a hazard or forward source.

Load-use stall:
- id_stall = id_valid & EX.valid & EX.is_load & EX.wb_en & ((id_uses_rs1 & id_rs1_addr==EX.rd) | (id_uses_rs2 & id_rs2_addr==EX.rd)).
- A stall lasts exactly one cycle per hazard, because the load moves to MEM and its result is then forwarded.

Redirect:
- id_flush = ex_redirect.
- Redirect overrides stall: id_stall is forced to 0 when ex_redirect is 1.
- The branch itself in EX proceeds to MEM normally.

Forwarding (per operand, EX source reg r, used flag u):
- FWD_MEM if u & MEM.valid & MEM.wb_en & MEM.rd==r & !MEM.is_load.
- Else FWD_WB if u & WB.valid & WB.wb_en & WB.rd==r.
- Else FWD_RF.
- MEM takes priority over WB, because it is the younger instruction.
- A load in MEM is never a forward source; the stall guarantees it has reached WB before a dependent instruction uses it.
- The register file is write-first, so an ID read of the register WB is writing in the same cycle needs no forwarding.

Counters:
- Each counter increments by 1 on a cycle when its event output is high.
- Counters saturate at all-ones; no wrap.

## Timing
Reset:
- On rst, all valid tags are 0 and both counters are 0.
- During reset, id_stall=0, id_flush=0, wb_writeback_en=0, fwd selects=FWD_RF, wb_rd_addr=0.

Combinational outputs:
- id_stall, id_flush, fwd_*_sel and wb_* are combinational from registered tags and the current ID inputs and ex_redirect.
- No input-to-output path beyond these.

Latency:
- An instruction accepted in ID at cycle n is ex_valid at n+1, mem_valid at n+2 and wb_valid at n+3.

rst in mid-operation:
- rst asserted while stages are full kills all in-flight tags on the next edge.
- Nothing written after the reset edge.

## Structure
- Package riscv_pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF=0, FWD_MEM=1, FWD_WB=2;
  - stage_tag_t struct: valid, rd, wb_en, is_load, rs1, rs2, uses_rs1, uses_rs2.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated twice for the event counters.

## Test plan
- Back-to-back ALU ops: add x3,x1,x2 then add x4,x3,x3 → second op in EX has fwd_rs1_sel=fwd_rs2_sel=FWD_MEM, no stall.
- Distance-2 dependence: add x5 then nop then xor x6,x5,x0 → fwd_rs1_sel=FWD_WB; fwd_rs2_sel=FWD_RF (x0).
- Load-use: load x7 then add x8,x7,x1 → id_stall high one cycle, EX bubble, then FWD_WB for x7; stall_count=1.
- Redirect during stall: load-use stall cycle with ex_redirect=1 → id_stall=0, id_flush=1, EX gets bubble; flush_count=1.
- Writes to x0: add x0 then add x9,x0,x0 → all selects FWD_RF, wb_writeback_en=0 for the x0 op.
- Reset mid-stream: three valid stages, pulse rst → next cycle all valids 0, counters 0, no wb_writeback_en; counter saturation checked with CNT_W=4 after 20 stall cycles → 15.
